xor_stim_checker: RTL and testbench

XOR_STIM_CHECKER -- requirements
Module: xor_stim_checker

---
 rtl/xor_tb_pkg.sv | 20 ++
 rtl/settle_timer.sv | 28 ++
 rtl/xor_stim_checker.sv | 146 ++++++++++++++
 tb/tb_xor_stim_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_tb_pkg.sv
// Shared types and constants for the XOR stimulus/response checker.
// Holds the FSM state encoding and the truth-table and error-count limits.
package xor_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam logic [3:0] ERR_MAX = 4'd15;

  // Error counter increment that sticks at ERR_MAX instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == ERR_MAX) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counting settle timer: load arms it, expire is high while the count is zero.
// The count only moves while enabled so it can sit idle between vectors.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/xor_stim_checker.sv
// Drives the 4-vector XOR truth table into a downstream stage and checks its response.
// Reports a mismatch count, the first failing vector and a pass verdict per run.
//
// state | meaning
// IDLE  | waiting for start, verdict registers hold last run result
// DRIVE | vector on dut_a/dut_b, waiting SETTLE_CYCLES for the stage to settle
// CHECK | one-cycle compare of dut_out against dut_a ^ dut_b
// DONE  | one-cycle done pulse, pass verdict valid
module xor_stim_checker
  import xor_tb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t     state, next_state;
  logic [1:0] vec_idx, vec_nxt;
  logic [3:0] pass_idx, pass_nxt;
  logic       timer_load;
  logic       timer_expire;
  logic       mismatch;
  logic       drive_nxt;

  settle_timer #(
    .W(4)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (state == DRIVE),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencing of vectors and passes lives here with the transitions that consume it.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    vec_nxt    = vec_idx;
    pass_nxt   = pass_idx;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = DRIVE;
          timer_load = 1'b1;
          vec_nxt    = 2'd0;
          pass_nxt   = 4'd0;
        end
      end
      DRIVE: begin
        if (timer_expire) begin
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (vec_idx != LAST_VEC) begin
          next_state = DRIVE;
          timer_load = 1'b1;
          vec_nxt    = vec_idx + 2'd1;
        end else if (pass_idx != LAST_PASS) begin
          next_state = DRIVE;
          timer_load = 1'b1;
          vec_nxt    = 2'd0;
          pass_nxt   = pass_idx + 4'd1;
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mismatch  = (state == CHECK) && (dut_out != (dut_a ^ dut_b));
    drive_nxt = (next_state == DRIVE) || (next_state == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx  <= 2'd0;
      pass_idx <= 4'd0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
    end else begin
      vec_idx  <= vec_nxt;
      pass_idx <= pass_nxt;
      dut_a    <= drive_nxt & vec_nxt[1];
      dut_b    <= drive_nxt & vec_nxt[0];
    end
  end

  // A zero err_count means no mismatch yet this run, so it doubles as the first-failure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 4'd0;
      fail_vec  <= 2'b00;
      pass      <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err_count <= 4'd0;
      fail_vec  <= 2'b00;
      pass      <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (err_count == 4'd0) begin
          fail_vec <= {dut_a, dut_b};
        end
      end
      if ((state == CHECK) && (next_state == DONE)) begin
        pass <= (err_count == 4'd0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_xor_stim_checker.sv
// Scoreboard bench: three checker instances with different settle/pass settings,
// each driving a modelled XOR stage with injectable per-vector faults and optional delay.
module tb_xor_stim_checker;

  typedef struct {
    int         inst;
    int         p;
    int         lat;
    int         pass;
    int         err;
    int         fv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start   [3];
  logic       dut_a   [3];
  logic       dut_b   [3];
  logic       dut_out [3];
  logic       busy    [3];
  logic       done    [3];
  logic       pass    [3];
  logic [3:0] err     [3];
  logic [1:0] fv      [3];
  logic [3:0] fault   [3];
  logic       del     [3];
  logic       prev    [3];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  function automatic int sc_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  function automatic int np_of(input int g);
    return (g == 1) ? 4 : 1;
  endfunction

  function automatic int lat_of(input int g);
    return np_of(g) * 4 * (sc_of(g) + 1) + 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    xor_stim_checker #(
      .SETTLE_CYCLES ((g == 2) ? 1 : 2),
      .NUM_PASSES    ((g == 1) ? 4 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .dut_a     (dut_a[g]),
      .dut_b     (dut_b[g]),
      .dut_out   (dut_out[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (err[g]),
      .fail_vec  (fv[g])
    );

    // XOR stage model: ideal XOR, optionally corrupted per vector, optionally one cycle late.
    wire cur_xor = dut_a[g] ^ dut_b[g] ^ fault[g][{dut_a[g], dut_b[g]}];
    always @(posedge clk) prev[g] <= cur_xor;
    assign dut_out[g] = del[g] ? prev[g] : cur_xor;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  // Reference: every pass sees the same faulty vectors; count saturates, first fault wins.
  function automatic exp_t make_exp(input int g, input logic [3:0] f, input int p);
    exp_t e;
    int   n;
    n      = np_of(g) * $countones(f);
    e.inst = g;
    e.p    = p;
    e.lat  = lat_of(g);
    e.err  = (n > 15) ? 15 : n;
    e.pass = (n == 0) ? 1 : 0;
    e.fv   = 0;
    for (int v = 3; v >= 0; v--) if (f[v]) e.fv = v;
    return e;
  endfunction

  // Monitor: pops on done, otherwise checks the vector being driven for the oldest pending run.
  always @(negedge clk) begin : monitor
    int   idx[$];
    exp_t e;
    int   n;
    for (int g = 0; g < 3; g++) begin
      idx = q.find_first_index(x) with (x.inst == g);
      if (done[g]) begin
        if (idx.size() == 0) begin
          chk($sformatf("unexpected_done%0d", g), 1, 0);
        end else begin
          e = q[idx[0]];
          q.delete(idx[0]);
          chk($sformatf("done_cycle%0d", g), cyc - e.p + 1, e.lat);
          chk($sformatf("pass%0d", g), int'(pass[g]), e.pass);
          chk($sformatf("err_count%0d", g), int'(err[g]), e.err);
          chk($sformatf("fail_vec%0d", g), int'(fv[g]), e.fv);
          chk($sformatf("ab_done%0d", g), int'({dut_a[g], dut_b[g]}), 0);
        end
      end else if (idx.size() != 0) begin
        e = q[idx[0]];
        n = cyc - e.p;
        if (n >= 0 && n <= e.lat - 2) begin
          chk($sformatf("busy%0d", g), int'(busy[g]), 1);
          chk($sformatf("vector%0d", g), int'({dut_a[g], dut_b[g]}), (n / (sc_of(g) + 1)) % 4);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int pending(input int g);
    int idx[$];
    idx = q.find_index(x) with (x.inst == g);
    return idx.size();
  endfunction

  task automatic wait_drain(input int g, input int budget);
    int k = 0;
    while (pending(g) != 0 && k < budget) begin
      tick();
      k++;
    end
    if (pending(g) != 0) begin
      chk($sformatf("timeout%0d", g), 0, 1);
      q = q.find(x) with (x.inst != g);
    end
  endtask

  task automatic wait_idle(input int g);
    int k = 0;
    while (busy[g] && k < 200) begin
      tick();
      k++;
    end
    chk($sformatf("idle%0d", g), int'(busy[g]), 0);
  endtask

  task automatic chk_outputs(input int g, input int p, input int e, input int f);
    chk($sformatf("hold_busy%0d", g), int'(busy[g]), 0);
    chk($sformatf("hold_done%0d", g), int'(done[g]), 0);
    chk($sformatf("hold_ab%0d", g), int'({dut_a[g], dut_b[g]}), 0);
    chk($sformatf("hold_pass%0d", g), int'(pass[g]), p);
    chk($sformatf("hold_err%0d", g), int'(err[g]), e);
    chk($sformatf("hold_fv%0d", g), int'(fv[g]), f);
  endtask

  task automatic run(input int g, input logic [3:0] f, input logic d, input int extra);
    exp_t e;
    wait_idle(g);
    fault[g] = f;
    del[g]   = d;
    e = make_exp(g, f, cyc + 1);
    q.push_back(e);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    if (extra > 0) begin
      while (cyc - e.p < extra) tick();
      start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
    end
    wait_drain(g, 300);
    repeat (3) tick();
    chk_outputs(g, e.pass, e.err, e.fv);
  endtask

  task automatic held_run(input int g);
    exp_t e1, e2;
    wait_idle(g);
    fault[g] = 4'b0000;
    del[g]   = 1'b0;
    e1 = make_exp(g, 4'b0000, cyc + 1);
    e2 = make_exp(g, 4'b0000, e1.p + e1.lat + 1);
    q.push_back(e1);
    q.push_back(e2);
    start[g] = 1'b1;
    wait_drain(g, 300);
    start[g] = 1'b0;
    repeat (4) tick();
    chk_outputs(g, 1, 0, 0);
  endtask

  task automatic reset_mid_run();
    exp_t e;
    wait_idle(0);
    fault[0] = 4'b0110;
    del[0]   = 1'b0;
    e = make_exp(0, 4'b0110, cyc + 1);
    q.push_back(e);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    while (cyc - e.p < 6) tick();
    chk("err_before_reset", int'(err[0]), 1);
    #2 rst_n = 1'b0;
    q = q.find(x) with (x.inst != 0);
    #1;
    chk_outputs(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk_outputs(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      fault[g] = 4'b0000;
      del[g]   = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) chk_outputs(g, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run(0, 4'b0000, 1'b0, 0);
    run(0, 4'b0110, 1'b0, 0);
    run(1, 4'b1111, 1'b0, 0);
    run(2, 4'b0000, 1'b1, 0);
    run(0, 4'b0000, 1'b0, 5);
    held_run(2);
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
    end
    reset_mid_run();
    run(0, 4'b0000, 1'b0, 0);
    run(0, 4'b1000, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
